// File: rtl/bp_pkg.sv
// Branch predictor shared definitions.
//   - Default datapath width and BTB index width.
//   - 2-bit counter encodings (strong/weak not-taken, weak/strong taken).
//   - BTB entry record and helpers that split a PC into table index and tag.
//   The index skips pc[1:0]; the tag is everything above the index.
package bp_pkg;

  localparam int XLEN     = 32;
  localparam int IDX_BITS = 6;
  localparam int TAG_W    = XLEN - IDX_BITS - 2;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       ctr;
  } btb_entry_t;

  // Shift-then-truncate rather than part-select so every PC bit is consumed.
  function automatic logic [IDX_BITS-1:0] bp_index(input logic [XLEN-1:0] pc);
    return IDX_BITS'(pc >> 2);
  endfunction

  function automatic logic [TAG_W-1:0] bp_tag(input logic [XLEN-1:0] pc);
    return TAG_W'(pc >> (IDX_BITS + 2));
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/resolve bus of the branch predictor.
//   fetch side  : f_valid, f_pc in; p_valid, p_taken, p_target out
//   resolve side: r_valid, r_is_branch, r_pc, r_taken, r_target,
//                 r_pred_taken, r_pred_target in; mispredict, redirect_pc out
// master = pipeline driving requests, slave = predictor.
interface branch_predictor_if #(parameter int XLEN = 32);

  logic            f_valid;
  logic [XLEN-1:0] f_pc;
  logic            p_valid;
  logic            p_taken;
  logic [XLEN-1:0] p_target;

  logic            r_valid;
  logic            r_is_branch;
  logic [XLEN-1:0] r_pc;
  logic            r_taken;
  logic [XLEN-1:0] r_target;
  logic            r_pred_taken;
  logic [XLEN-1:0] r_pred_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output f_valid, f_pc, r_valid, r_is_branch, r_pc, r_taken, r_target,
           r_pred_taken, r_pred_target,
    input  p_valid, p_taken, p_target, mispredict, redirect_pc
  );

  modport slave (
    input  f_valid, f_pc, r_valid, r_is_branch, r_pc, r_taken, r_target,
           r_pred_taken, r_pred_target,
    output p_valid, p_taken, p_target, mispredict, redirect_pc
  );

endinterface

// File: rtl/sat_ctr2.sv
// 2-bit saturating counter next-state.
//   ctr      : current counter
//   taken    : branch outcome
//   ctr_next : counter moved one step toward the outcome, clamped at 00/11
module sat_ctr2
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit direction counter per entry.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : branch_predictor_if.slave (fetch lookup + resolve/redirect)
//   stat_branches, stat_mispredicts : saturating counters, present only
//                                     when BP_STATS_EN is defined
// Lookup and mispredict outputs are registered (1-cycle latency). Table
// writes land at the same edge that samples the lookup, so a same-index
// lookup sees the pre-update entry.
module branch_predictor
#(
  parameter int XLEN     = bp_pkg::XLEN,
  parameter int IDX_BITS = bp_pkg::IDX_BITS
)
(
  input  logic                clk,
  input  logic                rst,
  branch_predictor_if.slave   bus
`ifdef BP_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
`endif
);

  import bp_pkg::*;

  localparam int ENTRIES = 1 << IDX_BITS;

  // valid/ctr are reset; tag/target are don't-care until allocated.
  logic             valid_q [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];

  logic [IDX_BITS-1:0] f_idx, r_idx;
  btb_entry_t          f_ent;
  logic                f_taken;
  logic                r_hit;
  logic [1:0]          ctr_nxt;
  logic                upd, wr_hit, alloc;
  logic                mp_d;
  logic [XLEN-1:0]     redir_d;

  assign f_idx   = bp_index(bus.f_pc);
  assign f_ent   = '{valid:  valid_q[f_idx],
                     tag:    tag_q[f_idx],
                     target: tgt_q[f_idx],
                     ctr:    ctr_q[f_idx]};
  assign f_taken = f_ent.valid && (f_ent.tag == bp_tag(bus.f_pc)) && f_ent.ctr[1];

  assign r_idx = bp_index(bus.r_pc);
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == bp_tag(bus.r_pc));

  sat_ctr2 u_ctr (
    .ctr      (ctr_q[r_idx]),
    .taken    (bus.r_taken),
    .ctr_next (ctr_nxt)
  );

  assign upd    = bus.r_valid && bus.r_is_branch;
  assign wr_hit = upd && r_hit;
  assign alloc  = upd && !r_hit && bus.r_taken;

  // A non-branch predicted taken is an alias hit: redirect to the fall-through.
  always_comb begin
    mp_d    = 1'b0;
    redir_d = bus.r_pc + XLEN'(4);
    if (bus.r_valid) begin
      if (bus.r_is_branch) begin
        mp_d = (bus.r_taken != bus.r_pred_taken) ||
               (bus.r_taken && bus.r_pred_taken && (bus.r_target != bus.r_pred_target));
        if (bus.r_taken) redir_d = bus.r_target;
      end else begin
        mp_d = bus.r_pred_taken;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (wr_hit) begin
      ctr_q[r_idx] <= ctr_nxt;
    end else if (alloc) begin
      valid_q[r_idx] <= 1'b1;
      ctr_q[r_idx]   <= CTR_WT;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc || (wr_hit && bus.r_taken)) begin
      tag_q[r_idx] <= bp_tag(bus.r_pc);
      tgt_q[r_idx] <= bus.r_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.p_valid     <= 1'b0;
      bus.p_taken     <= 1'b0;
      bus.p_target    <= '0;
      bus.mispredict  <= 1'b0;
      bus.redirect_pc <= '0;
    end else begin
      bus.p_valid     <= bus.f_valid;
      bus.p_taken     <= bus.f_valid && f_taken;
      bus.p_target    <= (bus.f_valid && f_taken) ? f_ent.target : '0;
      bus.mispredict  <= mp_d;
      bus.redirect_pc <= mp_d ? redir_d : '0;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (mp_d && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, all checked against a table-of-records reference model.
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(32)) bus ();

`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_predictor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: one record per BTB slot, counter as an integer 0..3.
  bit          mv   [64];
  logic [31:0] mtag [64];
  logic [31:0] mtgt [64];
  int          mctr [64];
  int          exp_br = 0;
  int          exp_mp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mv[i]   = 1'b0;
      mctr[i] = 1;
    end
    exp_br = 0;
    exp_mp = 0;
  endtask

  task automatic model_lookup(input logic [31:0] pc, output bit taken, output logic [31:0] tgt);
    int i;
    i = int'((pc / 4) % 64);
    taken = mv[i] && (mtag[i] == pc / 256) && (mctr[i] >= 2);
    tgt   = taken ? mtgt[i] : 32'h0;
  endtask

  task automatic drive(input bit fv, input logic [31:0] fpc,
                       input bit rv, input bit rb, input logic [31:0] rpc,
                       input bit rt, input logic [31:0] rtg,
                       input bit rpt, input logic [31:0] rptg);
    bus.f_valid = fv;  bus.f_pc = fpc;
    bus.r_valid = rv;  bus.r_is_branch = rb; bus.r_pc = rpc;
    bus.r_taken = rt;  bus.r_target = rtg;
    bus.r_pred_taken = rpt; bus.r_pred_target = rptg;
  endtask

  // One clock: predict from the model (pre-update), apply the resolve, then
  // compare the registered DUT outputs just after the edge.
  task automatic cycle(input string tag);
    bit          e_pt, e_mp, hit;
    logic [31:0] e_ptg, e_rd;
    int          i;
    model_lookup(bus.f_pc, e_pt, e_ptg);
    if (!bus.f_valid) begin e_pt = 0; e_ptg = 0; end
    e_mp = 0;
    e_rd = bus.r_pc + 32'd4;
    if (bus.r_valid) begin
      if (bus.r_is_branch) begin
        e_mp = (bus.r_taken != bus.r_pred_taken) ||
               (bus.r_taken && bus.r_pred_taken && bus.r_target != bus.r_pred_target);
        if (bus.r_taken) e_rd = bus.r_target;
        exp_br++;
        i   = int'((bus.r_pc / 4) % 64);
        hit = mv[i] && (mtag[i] == bus.r_pc / 256);
        if (hit) begin
          mctr[i] = bus.r_taken ? ((mctr[i] == 3) ? 3 : mctr[i] + 1)
                                : ((mctr[i] == 0) ? 0 : mctr[i] - 1);
          if (bus.r_taken) mtgt[i] = bus.r_target;
        end else if (bus.r_taken) begin
          mv[i] = 1'b1; mtag[i] = bus.r_pc / 256; mtgt[i] = bus.r_target; mctr[i] = 2;
        end
      end else begin
        e_mp = bus.r_pred_taken;
      end
    end
    if (e_mp) exp_mp++;
    @(posedge clk); #1;
    chk({tag, ".p_valid"},  32'(bus.p_valid),  32'(bus.f_valid));
    chk({tag, ".p_taken"},  32'(bus.p_taken),  32'(e_pt));
    chk({tag, ".p_target"}, bus.p_target,      e_ptg);
    chk({tag, ".mispredict"}, 32'(bus.mispredict), 32'(e_mp));
    if (e_mp) chk({tag, ".redirect_pc"}, bus.redirect_pc, e_rd);
  endtask

  task automatic idle();
    drive(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    logic [31:0] rpc, rtg;
    bit          pt;
    logic [31:0] ptg;

    model_reset();
    idle();
    #12;
    chk("rst.p_valid",     32'(bus.p_valid), 32'h0);
    chk("rst.p_taken",     32'(bus.p_taken), 32'h0);
    chk("rst.p_target",    bus.p_target,     32'h0);
    chk("rst.mispredict",  32'(bus.mispredict), 32'h0);
    chk("rst.redirect_pc", bus.redirect_pc,  32'h0);
    @(negedge clk); rst = 1'b0;

    // Cold lookup misses.
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);                      cycle("cold");
    // Taken branch not in table: allocate and redirect to target.
    drive(0, 0, 1, 1, 32'h100, 1, 32'h200, 0, 0);                cycle("alloc");
    idle();                                                      cycle("alloc_drop");
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);                      cycle("alloc_hit");
    // Two not-taken resolves: 10 -> 01 -> 00.
    drive(0, 0, 1, 1, 32'h100, 0, 32'h200, 1, 32'h200);          cycle("nt1");
    drive(0, 0, 1, 1, 32'h100, 0, 32'h200, 0, 0);                cycle("nt2");
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);                      cycle("nt_look");
    // Alias eviction.
    drive(0, 0, 1, 1, 32'h100, 1, 32'h200, 0, 0);                cycle("al_a");
    drive(0, 0, 1, 1, 32'h100 + (32'd4 << 6), 1, 32'h300, 0, 0); cycle("al_b");
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);                      cycle("al_old");
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);                      cycle("al_new");
    // Non-branch predicted taken at top of address space: fall-through wraps.
    drive(0, 0, 1, 0, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h1234);     cycle("nonbr");
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);                      cycle("nonbr_look");
    // r_valid=0 ignores everything else.
    drive(0, 0, 0, 1, 32'h200, 0, 32'h0, 1, 32'h300);            cycle("rv0");
    // Same-cycle lookup and update to one index: old contents returned.
    drive(1, 32'h200, 1, 1, 32'h200, 0, 32'h0, 1, 32'h300);      cycle("rbw");
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);                      cycle("rbw_after");
    // Taken with wrong target.
    drive(0, 0, 1, 1, 32'h400, 1, 32'h500, 1, 32'h600);          cycle("badtgt");
`ifdef BP_STATS_EN
    chk("stat_branches",    stat_branches,    32'(exp_br));
    chk("stat_mispredicts", stat_mispredicts, 32'(exp_mp));
`endif

    // Randomized traffic over a small PC pool to provoke hits and aliasing.
    for (int n = 0; n < 400; n++) begin
      rpc = 32'h1000 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
      rtg = $urandom_range(0, 1) ? 32'h2000 : 32'h3000;
      model_lookup(rpc, pt, ptg);
      if ($urandom_range(0, 3) == 0) begin
        pt  = bit'($urandom_range(0, 1));
        ptg = $urandom_range(0, 1) ? 32'h2000 : 32'h3000;
      end
      drive(bit'($urandom_range(0, 1)),
            32'h1000 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 3)) << 2),
            bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 7) != 0), rpc,
            bit'($urandom_range(0, 1)), rtg, pt, ptg);
      cycle("rand");
    end
`ifdef BP_STATS_EN
    chk("rand.stat_branches",    stat_branches,    32'(exp_br));
    chk("rand.stat_mispredicts", stat_mispredicts, 32'(exp_mp));
`endif

    // Reset while a mispredict is being presented.
    drive(1, 32'h1000, 1, 1, 32'h1000, 1, 32'h7770, 0, 0);       cycle("pre_rst");
    idle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst.mispredict",  32'(bus.mispredict), 32'h0);
    chk("arst.redirect_pc", bus.redirect_pc,     32'h0);
    chk("arst.p_valid",     32'(bus.p_valid),    32'h0);
    chk("arst.p_taken",     32'(bus.p_taken),    32'h0);
`ifdef BP_STATS_EN
    chk("arst.stat_branches",    stat_branches,    32'h0);
    chk("arst.stat_mispredicts", stat_mispredicts, 32'h0);
`endif
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    drive(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0);                     cycle("post_rst_a");
    drive(1, 32'h100,  0, 0, 0, 0, 0, 0, 0);                     cycle("post_rst_b");
    drive(1, 32'h200,  0, 0, 0, 0, 0, 0, 0);                     cycle("post_rst_c");
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
